// File: rtl/wb_fifo_ep_pkg.sv
// wb_fifo_ep_pkg: shared constants, decode type and helpers for the Wishbone
// FIFO endpoint.
//   - Window select (wb_addr[AW-1]) and register offsets (wb_addr[0]).
//   - STATUS bit positions for levels (read) and flush controls (write).
//   - decode_sel(): window/offset -> access target.
//   - pack_status(): builds the 32-bit STATUS read value from both levels.
package wb_fifo_ep_pkg;

    localparam logic WIN_DATA   = 1'b0;
    localparam logic WIN_REG    = 1'b1;
    localparam logic REG_STATUS = 1'b0;
    localparam logic REG_DROP   = 1'b1;

    localparam int TXLVL_LSB = 0;
    localparam int RXLVL_LSB = 16;
    localparam int FLUSH_TX  = 0;
    localparam int FLUSH_RX  = 1;

    typedef enum logic [1:0] {
        SEL_DATA   = 2'd0,
        SEL_STATUS = 2'd1,
        SEL_DROP   = 2'd2
    } sel_e;

    function automatic sel_e decode_sel(input logic win, input logic off);
        sel_e sel;
        if (win == WIN_DATA) begin
            sel = SEL_DATA;
        end else if (off == REG_STATUS) begin
            sel = SEL_STATUS;
        end else begin
            sel = SEL_DROP;
        end
        return sel;
    endfunction

    // Levels arrive zero-extended to 16 bits; unused bits read as 0.
    function automatic logic [31:0] pack_status(input logic [15:0] tx_lvl,
                                                input logic [15:0] rx_lvl);
        logic [31:0] word;
        word = 32'd0;
        word[TXLVL_LSB +: 16] = tx_lvl;
        word[RXLVL_LSB +: 16] = rx_lvl;
        return word;
    endfunction

endpackage

// File: rtl/wb_fifo_ep_fifo_sync_lvl.sv
// fifo_sync_lvl: single-clock first-word-fall-through FIFO with flush and
// level output. The memory has a synchronous write and a registered read
// addressed by the *next* read pointer, so it maps onto block RAM; a bypass
// on the output register covers the case where the word being written is the
// one that becomes the new head.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         clear pointers/level; wins over push and pop this cycle
//   wr_en/wr_data push request and data (accepted if not full, or if full
//                 and popping in the same cycle)
//   rd_en         pop request (ignored when empty)
//   rd_data       current head word (valid while ~empty)
//   level         occupancy, 0..2^FLW
//   full, empty   level flags
module fifo_sync_lvl #(
    parameter int DW  = 32,
    parameter int FLW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           wr_en,
    input  logic [DW-1:0]  wr_data,
    input  logic           rd_en,
    output logic [DW-1:0]  rd_data,
    output logic [FLW:0]   level,
    output logic           full,
    output logic           empty
);

    localparam int             DEPTH    = 2 ** FLW;
    localparam logic [FLW:0]   LVL_FULL = (FLW + 1)'(DEPTH);
    localparam logic [FLW:0]   LVL_ZERO = (FLW + 1)'(0);
    localparam logic [FLW:0]   LVL_ONE  = (FLW + 1)'(1);
    localparam logic [FLW-1:0] PTR_ZERO = FLW'(0);
    localparam logic [FLW-1:0] PTR_ONE  = FLW'(1);

    logic [DW-1:0]  mem_r [DEPTH];
    logic [DW-1:0]  head_r;
    logic [FLW-1:0] wr_ptr_r;
    logic [FLW-1:0] rd_ptr_r;
    logic [FLW-1:0] wr_ptr_nxt_s;
    logic [FLW-1:0] rd_ptr_nxt_s;
    logic [FLW:0]   level_r;
    logic [FLW:0]   level_nxt_s;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;

    assign full_s  = (level_r == LVL_FULL);
    assign empty_s = (level_r == LVL_ZERO);

    // Qualified push/pop and next pointer/level values.
    always_comb begin
        pop_s  = rd_en & ~empty_s & ~flush;
        push_s = wr_en & (~full_s | pop_s) & ~flush;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointer and level state; flush returns everything to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
        end
    end

    // Storage array, write port only; no reset so it can live in block RAM.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Registered read of the next head; bypass when that slot is written now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= {DW{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_r <= wr_data;
        end else begin
            head_r <= mem_r[rd_ptr_nxt_s];
        end
    end

    assign rd_data = head_r;
    assign level   = level_r;
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/wb_fifo_ep.sv
// wb_fifo_ep: Wishbone responder bridging a DMA master port to two streams.
// Data window (wb_addr[AW-1]=0, all offsets alias): writes push into the TX
// FIFO, reads pop from the RX FIFO. Register window: STATUS (levels / flush)
// at wb_addr[0]=0, DROP (timeout-drop counter) at wb_addr[0]=1. Wait states
// are inserted by withholding ack; with TIMEOUT>0 a stalled access is force-
// acked after TIMEOUT wait cycles (write discarded, read returns 0).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wb_addr/wb_we/wb_wdata   Wishbone request, held until ack
//   wb_cyc                   cycle/strobe
//   wb_ack, wb_rdata         registered one-cycle ack and read data
//   tx_data/tx_valid/tx_ready  outbound stream (TX FIFO head)
//   rx_data/rx_valid/rx_ready  inbound stream (into RX FIFO)
module wb_fifo_ep
    import wb_fifo_ep_pkg::*;
#(
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int FLW     = 8,
    parameter int TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_rdata,
    input  logic [DW-1:0] wb_wdata,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    localparam bit            TO_EN  = (TIMEOUT > 0);
    localparam int            TW     = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);
    localparam logic [TW-1:0] TW_ONE = TW'(1);
    localparam logic [15:0]   DROP_MAX = 16'hFFFF;

    sel_e          sel_s;
    logic          ok_s;
    logic          ack_set_s;
    logic          force_s;
    logic          ack_nxt_s;
    logic          tx_push_s;
    logic          tx_pop_s;
    logic          tx_flush_s;
    logic          rx_push_s;
    logic          rx_pop_s;
    logic          rx_flush_s;
    logic          drop_clr_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic [FLW:0]  tx_level_s;
    logic [FLW:0]  rx_level_s;
    logic [DW-1:0] rx_head_s;
    logic [31:0]   status_s;
    logic [DW-1:0] rdata_nxt_s;
    logic          addr_unused_s;

    logic          wb_ack_r;
    logic [DW-1:0] wb_rdata_r;
    logic [TW-1:0] wait_cnt_r;
    logic [15:0]   drop_cnt_r;

    // Middle address bits only matter to the master's own sequencing.
    assign addr_unused_s = ^wb_addr[AW-2:1];

    assign status_s = pack_status(16'(tx_level_s), 16'(rx_level_s));

    // Decode, ready condition, normal and forced ack, and FIFO/register strobes.
    always_comb begin
        sel_s = decode_sel(wb_addr[AW-1], wb_addr[0]);
        case (sel_s)
            SEL_DATA: begin
                if (wb_we) begin
                    ok_s = ~tx_full_s;
                end else begin
                    ok_s = ~rx_empty_s;
                end
            end
            SEL_STATUS: ok_s = 1'b1;
            SEL_DROP:   ok_s = 1'b1;
            default:    ok_s = 1'b1;
        endcase
        ack_set_s = ~wb_ack_r & wb_cyc & ok_s;
        if (TO_EN) begin
            force_s = ~wb_ack_r & wb_cyc & ~ok_s & (wait_cnt_r == TO_VAL);
        end else begin
            force_s = 1'b0;
        end
        ack_nxt_s  = ack_set_s | force_s;
        tx_push_s  = ack_set_s & (sel_s == SEL_DATA) & wb_we;
        rx_pop_s   = ack_set_s & (sel_s == SEL_DATA) & ~wb_we;
        tx_flush_s = ack_set_s & (sel_s == SEL_STATUS) & wb_we & wb_wdata[FLUSH_TX];
        rx_flush_s = ack_set_s & (sel_s == SEL_STATUS) & wb_we & wb_wdata[FLUSH_RX];
        drop_clr_s = ack_set_s & (sel_s == SEL_DROP) & wb_we;
        tx_pop_s   = ~tx_empty_s & tx_ready;
        rx_push_s  = rx_valid & ~rx_full_s;
    end

    // Read data for the ack cycle; zero otherwise, including forced reads.
    always_comb begin
        rdata_nxt_s = {DW{1'b0}};
        if (ack_set_s && !wb_we) begin
            case (sel_s)
                SEL_DATA:   rdata_nxt_s = rx_head_s;
                SEL_STATUS: rdata_nxt_s = DW'(status_s);
                SEL_DROP:   rdata_nxt_s = DW'(drop_cnt_r);
                default:    rdata_nxt_s = {DW{1'b0}};
            endcase
        end else begin
            rdata_nxt_s = {DW{1'b0}};
        end
    end

    // Registered ack and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_r   <= 1'b0;
            wb_rdata_r <= {DW{1'b0}};
        end else begin
            wb_ack_r   <= ack_nxt_s;
            wb_rdata_r <= rdata_nxt_s;
        end
    end

    // Wait-state counter: counts stalled cycles of the current access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= TW'(0);
        end else if (!wb_cyc || wb_ack_r || ack_nxt_s) begin
            wait_cnt_r <= TW'(0);
        end else if (TO_EN && !ok_s) begin
            wait_cnt_r <= wait_cnt_r + TW_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Saturating count of forced acks; any DROP write clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 16'd0;
        end else if (force_s) begin
            if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else if (drop_clr_s) begin
            drop_cnt_r <= 16'd0;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    fifo_sync_lvl #(.DW(DW), .FLW(FLW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (tx_flush_s),
        .wr_en   (tx_push_s),
        .wr_data (wb_wdata),
        .rd_en   (tx_pop_s),
        .rd_data (tx_data),
        .level   (tx_level_s),
        .full    (tx_full_s),
        .empty   (tx_empty_s)
    );

    fifo_sync_lvl #(.DW(DW), .FLW(FLW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (rx_flush_s),
        .wr_en   (rx_push_s),
        .wr_data (rx_data),
        .rd_en   (rx_pop_s),
        .rd_data (rx_head_s),
        .level   (rx_level_s),
        .full    (rx_full_s),
        .empty   (rx_empty_s)
    );

    assign wb_ack   = wb_ack_r;
    assign wb_rdata = wb_rdata_r;
    assign tx_valid = ~tx_empty_s;
    assign rx_ready = ~rx_full_s;

endmodule

// File: tb/tb_wb_fifo_ep.sv
// Directed bench for wb_fifo_ep (AW=9, DW=32, FLW=8, TIMEOUT=8).
module tb_wb_fifo_ep;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int FLW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_rdata;
    logic [DW-1:0] wb_wdata;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_ack;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_fifo_ep #(.AW(AW), .DW(DW), .FLW(FLW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
        .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One Wishbone access; waits = stall cycles before ack, -1 if none came.
    task automatic wb_xfer(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output int waits);
        wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1; waits = 0;
        tick;
        while (wb_ack !== 1'b1 && waits < 20) begin
            waits++;
            tick;
        end
        rd = wb_rdata;
        if (wb_ack !== 1'b1) waits = -1;
        tick;
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tick; tick;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", wb_ack); end
        n_cmp++; if (wb_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", wb_rdata); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_write;
        logic [DW-1:0] rd;
        int w;
        wb_xfer(9'h005, 1'b1, 32'hDEADBEEF, rd, w);
        n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL single_wr_latency: got %0d waits want 0", w); end
        n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL single_wr_tx_valid: got %b want 1", tx_valid); end
        n_cmp++; if (tx_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_wr_tx_data: got %h want deadbeef", tx_data); end
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00000001) begin n_bad++; $display("FAIL single_wr_status: got %h want 00000001", rd); end
        wb_xfer(9'h100, 1'b1, 32'h1, rd, w);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_wr_flush: tx_valid %b want 0", tx_valid); end
    endtask

    // WB push and stream pop on the same edge; then drain checking order.
    task automatic test_tx_stream;
        logic [DW-1:0] rd;
        int w;
        wb_xfer(9'h010, 1'b1, 32'h000000A0, rd, w);
        wb_xfer(9'h011, 1'b1, 32'h000000B0, rd, w);
        wb_addr = 9'h012; wb_we = 1'b1; wb_wdata = 32'h000000C0; wb_cyc = 1'b1; tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL pushpop_ack: got %b want 1", wb_ack); end
        n_cmp++; if (tx_data !== 32'h000000B0) begin n_bad++; $display("FAIL pushpop_head: got %h want 000000b0", tx_data); end
        tick;
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick;
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00000002) begin n_bad++; $display("FAIL pushpop_level: got %h want 00000002", rd); end
        tx_ready = 1'b1; tick; tx_ready = 1'b0;
        n_cmp++; if (tx_data !== 32'h000000C0) begin n_bad++; $display("FAIL tx_drain_order: got %h want 000000c0", tx_data); end
        tx_ready = 1'b1; tick; tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_drain_empty: tx_valid %b want 0", tx_valid); end
    endtask

    task automatic test_burst;
        logic [DW-1:0] rd;
        int w;
        int bad;
        int n;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            wb_xfer(AW'(i & 255), 1'b1, 32'h00001000 + i, rd, w);
            if (w != 0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL burst_acks: %0d late acks want 0", bad); end
        // 257th write must stall while full
        wb_addr = 9'h000; wb_we = 1'b1; wb_wdata = 32'h00002000; wb_cyc = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (wb_ack !== 1'b0) n++;
        end
        n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL burst_full_stall: %0d acks want 0", n); end
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL burst_pop_cycle_ack: got %b want 0", wb_ack); end
        tick;
        n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL burst_ack_after_pop: got %b want 1", wb_ack); end
        tick;
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick;
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00000100) begin n_bad++; $display("FAIL burst_level: got %h want 00000100", rd); end
        n_cmp++; if (tx_data !== 32'h00001001) begin n_bad++; $display("FAIL burst_head: got %h want 00001001", tx_data); end
        wb_xfer(9'h100, 1'b1, 32'h1, rd, w);
    endtask

    task automatic test_rx_stream;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_words [3];
        int w;
        int n;
        int bad;
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = exp_words[i];
            tick;
        end
        rx_valid = 1'b0;
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00030000) begin n_bad++; $display("FAIL rx_level: got %h want 00030000", rd); end
        for (int i = 0; i < 3; i++) begin
            wb_xfer(AW'(i), 1'b0, 32'h0, rd, w);
            n_cmp++; if (rd !== exp_words[i] || w !== 0) begin n_bad++; $display("FAIL rx_read%0d: got %h waits %0d want %h waits 0", i, rd, w, exp_words[i]); end
        end
        // Fourth read: empty, stalls with rdata 0, then forced by timeout
        wb_addr = 9'h003; wb_we = 1'b0; wb_cyc = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rx_stall: %0d bad cycles want 0", bad); end
        n = 4;
        while (wb_ack !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        n_cmp++; if (n !== TO + 1) begin n_bad++; $display("FAIL timeout_latency: ack at cycle %0d want %0d", n, TO + 1); end
        n_cmp++; if (wb_rdata !== 32'h0) begin n_bad++; $display("FAIL timeout_rdata: got %h want 0", wb_rdata); end
        tick;
        wb_cyc = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        logic [DW-1:0] rd;
        int w;
        wb_xfer(9'h101, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00000001) begin n_bad++; $display("FAIL drop_count: got %h want 00000001", rd); end
        wb_xfer(9'h101, 1'b1, 32'h0, rd, w);
        wb_xfer(9'h1FF, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL drop_clear: got %h want 0", rd); end
    endtask

    task automatic test_flush_race;
        logic [DW-1:0] rd;
        int w;
        for (int i = 0; i < 5; i++) wb_xfer(9'h020, 1'b1, 32'h50 + i, rd, w);
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00000005) begin n_bad++; $display("FAIL flush_pre_level: got %h want 00000005", rd); end
        wb_addr = 9'h100; wb_we = 1'b1; wb_wdata = 32'h1; wb_cyc = 1'b1; tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL flush_race_tx_valid: got %b want 0", tx_valid); end
        tick;
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick;
        // RX flush with a stream push on the same edge (alias address)
        rx_valid = 1'b1; rx_data = 32'h77;
        tick; tick;
        wb_addr = 9'h102; wb_we = 1'b1; wb_wdata = 32'h2; wb_cyc = 1'b1;
        tick;
        rx_valid = 1'b0;
        tick;
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick;
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL flush_levels: got %h want 0", rd); end
    endtask

    task automatic test_async_reset;
        logic [DW-1:0] rd;
        int w;
        for (int i = 0; i < 3; i++) wb_xfer(9'h030, 1'b1, 32'h60 + i, rd, w);
        wb_addr = 9'h000; wb_we = 1'b0; wb_cyc = 1'b1;
        tick; tick;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL arst_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (rx_ready !== 1'b1 || wb_ack !== 1'b0) begin n_bad++; $display("FAIL arst_rx_ready_ack: got %b/%b want 1/0", rx_ready, wb_ack); end
        wb_cyc = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        // Ack in flight must drop the moment reset rises
        wb_addr = 9'h040; wb_we = 1'b1; wb_wdata = 32'h99; wb_cyc = 1'b1;
        tick;
        n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL arst_pre_ack: got %b want 1", wb_ack); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (wb_ack !== 1'b0 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL arst_ack_drop: ack %b tx_valid %b want 0/0", wb_ack, tx_valid); end
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        wb_xfer(9'h041, 1'b1, 32'h77, rd, w);
        wb_xfer(9'h100, 1'b0, 32'h0, rd, w);
        n_cmp++; if (rd !== 32'h00000001) begin n_bad++; $display("FAIL arst_restart_level: got %h want 00000001", rd); end
        n_cmp++; if (tx_data !== 32'h77) begin n_bad++; $display("FAIL arst_restart_head: got %h want 00000077", tx_data); end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_tx_stream;
        test_burst;
        test_rx_stream;
        test_timeout;
        test_flush_race;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
